hex_display_scanner: RTL
========================

# hex_display_scanner

Parametrised multiplexed seven-segment driver that replaces the fixed 32-bit HEX output path of the top-level `Main`. It captures a word from the core on a load strobe and presents it in hexadecimal or decimal, with a sequential binary-to-BCD converter, leading-zero blanking and overflow indication. It time-multiplexes `DIGITS` common-anode digits at a programmable refresh rate.

## Interface
- `DATA_W`, 32: width of the loaded value.
- `DIGITS`, 8: number of display digits; nibble field is 4*`DIGITS` bits.
- `REFRESH_DIV`, 50000: clock cycles each digit stays lit; must be at least 1.
- `clk` input 1: the single clock; all state is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `value_i` input `DATA_W`: value to display, sampled on an accepted load.
- `load_i` input 1: load strobe. It is accepted when `load_i`=1 and `busy_o`=0.
- `dec_mode_i` input 1: display mode, sampled with the load. 1 = decimal, 0 = hex.
- `blank_lz_i` input 1: leading-zero blanking, applied live.
- `busy_o` output 1: decimal conversion is in progress.
- `ovf_o` output 1: the last decimal load did not fit in `DIGITS` digits.
- `shown_o` output 4*`DIGITS`: the nibbles currently displayed. Digit 0 is in bits [3:0].
- `an_o` output `DIGITS`: digit anodes, active-low, one-hot.
- `seg_o` output 7: segments, active-low. Bit 0 is segment a and bit 6 is segment g.

## Operation
- Reset state:
  - `busy_o`=0, `ovf_o`=0, `shown_o`=0.
  - `an_o`=all ones and `seg_o`=7'h7F, so the display is dark.
  - Scan index = 0 and refresh counter = 0.
- Hex load (`dec_mode_i`=0):
  - `shown_o` takes the low 4*`DIGITS` bits of `value_i`, zero-extended if `DATA_W` is narrower.
  - `ovf_o` is cleared.
- Decimal load (`dec_mode_i`=1):
  - The value is captured and an internal double-dabble shift/add-3 conversion starts, one bit per cycle, `DATA_W` iterations.
  - The BCD scratch register holds 4*ceil(`DATA_W`/3) bits.
  - At completion, if any BCD digit at index `DIGITS` or above is non-zero, then `ovf_o`=1 and `shown_o`=all 4'hF.
  - Otherwise `ovf_o`=0 and `shown_o` takes the low `DIGITS` BCD digits.
- FSM states:
  - IDLE goes to CONV on a decimal load.
  - CONV counts `DATA_W` iterations, then goes to DONE.
  - DONE writes `shown_o` and `ovf_o`, then returns to IDLE.
  - `busy_o`=1 in CONV and DONE.
- `shown_o` is the only state visible to the scanner. While converting, the old value stays on the display and is never shown partially converted.
- Loads while `busy_o`=1 are ignored and not queued.
- Scanner:
  - The refresh counter counts 0..`REFRESH_DIV`-1 and wraps to 0.
  - On each wrap the scan index advances, going from `DIGITS`-1 back to 0.
- Digit decode, normal:
  - Nibbles 0-F use standard hex glyphs: 0=7'h40, 1=7'h79, 5=7'h12, 8=7'h00, A=7'h08, D=7'h21, F=7'h0E.
- Digit decode, overflow: when `ovf_o`=1, every digit shows a dash, 7'h3F (g only).
- Digit decode, blanking:
  - Digit i>0 is blanked (`seg_o`=7'h7F, anode still driven) when `blank_lz_i`=1, `ovf_o`=0 and nibbles i..`DIGITS`-1 are all zero.
  - Digit 0 is never blanked.
- `an_o` and `seg_o` are registered and glitch-free. Exactly one anode is low at any time after the first post-reset edge.

## Timing
- Hex load accepted at edge N: `shown_o` is valid after edge N. `busy_o` stays 0.
- Decimal load accepted at edge N:
  - `busy_o`=1 after edge N.
  - `shown_o` and `ovf_o` update, and `busy_o` returns to 0, after edge N+`DATA_W`+1.
  - The next load can be accepted at edge N+`DATA_W`+2.
- Display outputs follow `shown_o`, the scan index and `blank_lz_i` with 1 cycle of latency.
- Each digit is lit for exactly `REFRESH_DIV` cycles. A full frame takes `DIGITS`*`REFRESH_DIV` cycles.
- First edge after reset release: the digit 0 anode goes low.
- Reset asserted mid-conversion:
  - The conversion is aborted immediately and all outputs take their reset values.
  - No partial result is ever written.
- `load_i` held high while busy: exactly one load is taken per IDLE entry.
- `dec_mode_i` and `value_i` are ignored except in the load cycle.

## Test plan
- Reset with `REFRESH_DIV`=4:
  - During reset: `an_o`=8'hFF, `seg_o`=7'h7F, `busy_o`=0, `shown_o`=0.
  - After release: `an_o` steps 8'hFE, 8'hFD, … every 4 cycles and wraps back to 8'hFE after 32 cycles.
- Hex load of 32'h1234ABCD:
  - `shown_o`=32'h1234ABCD one cycle later.
  - Digit 0 shows `seg_o`=7'h21 ('D').
  - `busy_o` never rises.
- Decimal load of 12345678:
  - `busy_o` is high for 33 cycles.
  - Afterwards `shown_o`=32'h12345678 and `ovf_o`=0.
  - A second load pulsed at cycle 10 of the conversion is ignored.
- Decimal load of 32'hFFFFFFFF (4294967295): `ovf_o`=1, `shown_o`=32'hFFFFFFFF, and every digit shows 7'h3F.
- Hex load of 32'h000000A5 with `blank_lz_i`=1:
  - Digits 2-7 show 7'h7F, digit 1 shows 7'h08 ('A') and digit 0 shows 7'h12 ('5').
  - Loading 0 in the same setup shows only digit 0 as 7'h40.
- Decimal load, then `reset` pulsed low at conversion cycle 15: after release, `shown_o`=0, `ovf_o`=0, `busy_o`=0, and the following hex load works normally.

Source files
------------

// File: rtl/hex_display_scanner.sv
// Multiplexed seven-segment driver: hex or double-dabble decimal display of a loaded word.
// Latency: hex load 1 cycle, decimal load DATA_W+1 cycles; display outputs 1 cycle after shown_o/scan.
// Backpressure: busy_o high during decimal conversion; loads seen while busy are dropped, not queued.
module hex_display_scanner #(
    parameter int DATA_W      = 32,
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     value_i,
    input  logic                  load_i,
    input  logic                  dec_mode_i,
    input  logic                  blank_lz_i,
    output logic                  busy_o,
    output logic                  ovf_o,
    output logic [4*DIGITS-1:0]   shown_o,
    output logic [DIGITS-1:0]     an_o,
    output logic [6:0]            seg_o
);

    localparam int NW    = 4 * DIGITS;
    localparam int BCD_D = (DATA_W + 2) / 3;
    localparam int BCD_W = 4 * BCD_D;
    localparam int EXT_D = (BCD_D > DIGITS) ? BCD_D : DIGITS;
    localparam int EXT_W = 4 * EXT_D;
    localparam int CW    = $clog2(DATA_W + 1);
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] bin_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  bcd_adj;
    logic [CW-1:0]     iter_q;
    logic [EXT_W-1:0]  bcd_ext;
    logic              hi_nonzero;

    logic [RW-1:0]     ref_q;
    logic [IW-1:0]     idx_q;
    logic [3:0]        cur_nib;
    logic              upper_zero;
    logic [6:0]        seg_nxt;

    // Add-3 correction applied to every BCD digit before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < BCD_D; k++) begin
            if (bcd_q[4*k +: 4] > 4'd4) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    assign bcd_ext    = EXT_W'(bcd_q);
    assign hi_nonzero = |(bcd_ext >> NW);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            busy_o  <= 1'b0;
            ovf_o   <= 1'b0;
            shown_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_i) begin
                        if (dec_mode_i) begin
                            bin_q   <= value_i;
                            bcd_q   <= '0;
                            iter_q  <= '0;
                            busy_o  <= 1'b1;
                            state_q <= CONV;
                        end else begin
                            shown_o <= NW'(value_i);
                            ovf_o   <= 1'b0;
                        end
                    end
                end
                CONV: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    iter_q         <= iter_q + 1'b1;
                    if (iter_q == CW'(DATA_W - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (hi_nonzero) begin
                        ovf_o   <= 1'b1;
                        shown_o <= '1;
                    end else begin
                        ovf_o   <= 1'b0;
                        shown_o <= bcd_ext[NW-1:0];
                    end
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        cur_nib    = shown_o[{idx_q, 2'b00} +: 4];
        upper_zero = ((shown_o >> {idx_q, 2'b00}) == '0);
        if (ovf_o) begin
            seg_nxt = 7'h3F;
        end else if (blank_lz_i && (idx_q != '0) && upper_zero) begin
            seg_nxt = 7'h7F;
        end else begin
            seg_nxt = glyph(cur_nib);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_q <= '0;
            idx_q <= '0;
            an_o  <= '1;
            seg_o <= 7'h7F;
        end else begin
            if (ref_q == RW'(REFRESH_DIV - 1)) begin
                ref_q <= '0;
                idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                ref_q <= ref_q + 1'b1;
            end
            an_o  <= ~(DIGITS'(1) << idx_q);
            seg_o <= seg_nxt;
        end
    end

endmodule
